pixel_adc_responder: RTL and testbench
======================================

Name: pixel_adc_responder

Overview:
- Synthesizable digital model of the pixel side of the erase/expose/convert/read pixel protocol.
- Integrates a photo-voltage during exposure and compares it against a stepped ramp during conversion.
- When the ramp reaches the voltage, it latches the code present on the shared data bus. During readout it drives that latched code back onto the bus.
- Sits under the pixel-array controller and replaces the behavioural pixel in system simulation and FPGA builds.

Parameters:
- DATA_W, 8, width of ramp code and pixel data bus.
- FRAC_W, 8, fractional bits of the integrated voltage accumulator.
- PHOTO_RATE, 128, accumulator increment per exposure tick in Q0.FRAC_W (128 = 0.5 LSB/tick).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- erase_i  in  1  erase request (level).
- expose_i  in  1  expose request (level).
- expose_tick_i  in  1  one-cycle photo-integration strobe, valid only while in EXPOSE.
- convert_i  in  1  conversion window (level).
- ramp_tick_i  in  1  one-cycle ramp-step strobe, valid only while in CONVERT.
- read_i  in  1  readout request (level).
- bus_in  in  DATA_W  ramp code driven by the controller during conversion.
- bus_out  out  DATA_W  latched pixel code.
- bus_oe  out  1  bus_out drive enable; the top level builds the tri-state from it.
- conv_done_o  out  1  high once the comparator has tripped in the current conversion.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- **Reset.** Clock is clk. Reset is asynchronous and active-high. On reset: state=IDLE, v=0, ramp=0, data_q=0, tripped=0, bus_out=0, bus_oe=0, conv_done_o=0.
- **States:** IDLE=0, ERASE=1, EXPOSE=2, CONVERT=3, READ=4.
- **Next-state selection.** Next state is chosen every cycle from the request levels, with priority erase_i > read_i > expose_i > convert_i. No request selects IDLE. The state register updates on the posedge, so every state entry has 1 cycle of latency from the request.
- **ERASE:** v<=0, data_q<=0, tripped<=0.
- **EXPOSE:**
  - When expose_tick_i is high: v <= min(v + PHOTO_RATE, 2^(DATA_W+FRAC_W) - 1). Saturating; never wraps.
  - When expose_tick_i is low: v holds.
- **CONVERT entry** (previous state != CONVERT): ramp<=0, tripped<=0.
- **CONVERT, each cycle with ramp_tick_i high:**
  - Let vi = v[DATA_W+FRAC_W-1:FRAC_W].
  - If tripped=0 and ramp >= vi: data_q <= bus_in and tripped <= 1.
  - ramp increments, saturating at 2^DATA_W - 1. Because the ramp saturates, a trip is guaranteed no later than tick 2^DATA_W.
- **Ticks outside their state:** ramp_tick_i outside CONVERT and expose_tick_i outside EXPOSE are ignored.
- **Aborted conversion.** Leaving CONVERT before a trip leaves data_q unchanged and tripped=0. A later re-entry restarts the ramp at 0.
- **READ:** bus_oe=1 and bus_out=data_q, both registered, so they assert the cycle after read_i is sampled. In every other state bus_oe=0 and bus_out=0.
- **conv_done_o** = tripped. It clears on ERASE and on CONVERT entry.
- **Voltage retention.** v is retained across CONVERT, READ and IDLE. Only ERASE or reset clears it.
- **Reset mid-operation** returns all registers to their reset values immediately, regardless of state.

Decomposition:
- Shared package pixel_pkg holds:
  - state encoding constants;
  - DATA_W and FRAC_W defaults;
  - the saturation-max constant.
- One sub-module, pixel_integrator: the saturating accumulator.
  - Inputs: clk, reset, clear, add_en, increment.
  - Output: v.
  - Keeps the arithmetic apart from the FSM and the comparator logic.

Test Plan:
1. **Nominal frame.** Reset, then erase 5 cycles, expose with 255 ticks (v=0x7F80, vi=127), convert with bus_in = ramp value (0..255), then read 5 cycles -> trip at tick 127, bus_out=127 with bus_oe=1 starting 1 cycle after read_i, conv_done_o=1.
2. **Saturation.** PHOTO_RATE=255 with 300 expose ticks -> v saturates at 0xFFFF. Conversion ramp 0..255 -> trip only at ramp=255, bus_out=255.
3. **Dark pixel.** Erase then expose with 0 ticks -> trip on the first ramp tick, data_q = bus_in at tick 0 (0).
4. **Priority.** Assert erase_i and read_i together -> state=ERASE, bus_oe=0. Assert read_i and convert_i together -> READ, no ramp activity.
5. **Aborted conversion.** Drop convert_i at ramp=50 with vi=127 -> conv_done_o=0, data_q unchanged. Re-convert -> ramp restarts at 0 and trips at 127.
6. **Asynchronous reset.** Assert reset mid-CONVERT and mid-READ -> bus_oe, bus_out, v and state return to 0/IDLE without waiting for a clk edge.

Source files
------------

// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared types and constants for the pixel ADC responder:
//               FSM state encoding, default widths and the accumulator
//               saturation maximum.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

  // FSM state encoding; the numeric values are visible on state_o.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } state_t;

  localparam int c_data_w_default     = 8;
  localparam int c_frac_w_default     = 8;
  localparam int c_photo_rate_default = 128;

  // Largest value the integrated-voltage accumulator may hold with the
  // default widths (Q8.8 all ones).
  localparam logic [c_data_w_default+c_frac_w_default-1:0] c_v_max_default =
    {(c_data_w_default+c_frac_w_default){1'b1}};

endpackage : pixel_pkg
`default_nettype wire

// File: rtl/pixel_adc_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_adc_responder_if
// Description : Request/strobe/bus bundle between the pixel-array controller
//               (master) and one pixel responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_adc_responder_if #(
  parameter int DATA_W = 8
);
  logic              erase_i;
  logic              expose_i;
  logic              expose_tick_i;
  logic              convert_i;
  logic              ramp_tick_i;
  logic              read_i;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              conv_done_o;
  logic [2:0]        state_o;

  // Controller side: drives requests, strobes and the ramp code.
  modport master (
    output erase_i, expose_i, expose_tick_i, convert_i, ramp_tick_i, read_i, bus_in,
    input  bus_out, bus_oe, conv_done_o, state_o
  );

  // Pixel side: samples requests, returns its latched code and status.
  modport slave (
    input  erase_i, expose_i, expose_tick_i, convert_i, ramp_tick_i, read_i, bus_in,
    output bus_out, bus_oe, conv_done_o, state_o
  );
endinterface : pixel_adc_responder_if
`default_nettype wire

// File: rtl/pixel_integrator.sv
`default_nettype none
// ============================================================================
// Module      : pixel_integrator
// Description : Saturating photo-voltage accumulator. Adds the increment on
//               each enabled cycle and clamps at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_integrator #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         clear,
  input  wire logic         add_en,
  input  wire logic [W-1:0] increment,
  output logic      [W-1:0] v
);

  logic [W-1:0] r_v;
  logic [W:0]   w_sum;

  // One extra bit catches the carry that signals overflow.
  assign w_sum = {1'b0, r_v} + {1'b0, increment};

  // Clear has priority over accumulation; overflow clamps to all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= '0;
    end else if (clear) begin
      r_v <= '0;
    end else if (add_en) begin
      r_v <= w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    end
  end

  assign v = r_v;

endmodule : pixel_integrator
`default_nettype wire

// File: rtl/pixel_adc_responder.sv
`default_nettype none
// ============================================================================
// Module      : pixel_adc_responder
// Description : Pixel side of the erase/expose/convert/read protocol.
//               Integrates a photo-voltage, compares it with a stepped ramp,
//               latches the bus code at the trip point and drives it back
//               during readout.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_adc_responder
  import pixel_pkg::*;
#(
  parameter int DATA_W     = c_data_w_default,
  parameter int FRAC_W     = c_frac_w_default,
  parameter int PHOTO_RATE = c_photo_rate_default
) (
  input wire logic              clk,
  input wire logic              reset,
  pixel_adc_responder_if.slave  pif
);

  localparam int                  c_v_w       = DATA_W + FRAC_W;
  localparam logic [c_v_w-1:0]    c_increment = c_v_w'(PHOTO_RATE);
  localparam logic [DATA_W-1:0]   c_ramp_max  = {DATA_W{1'b1}};

  state_t              r_state;
  state_t              w_next_state;
  logic [c_v_w-1:0]    w_v;
  logic [DATA_W-1:0]   w_vi;
  logic [DATA_W-1:0]   r_ramp;
  logic [DATA_W-1:0]   w_ramp_next;
  logic [DATA_W-1:0]   r_data_q;
  logic [DATA_W-1:0]   w_data_q_next;
  logic                r_tripped;
  logic                w_tripped_next;
  logic [DATA_W-1:0]   r_bus_out;
  logic                r_bus_oe;
  logic                w_clear;
  logic                w_add_en;
  logic                w_convert_entry;

  // Integer part of the accumulated voltage is what the ramp is compared to.
  assign w_vi            = w_v[c_v_w-1:FRAC_W];
  assign w_clear         = (r_state == ST_ERASE);
  assign w_add_en        = (r_state == ST_EXPOSE) && pif.expose_tick_i;
  assign w_convert_entry = (w_next_state == ST_CONVERT) && (r_state != ST_CONVERT);

  pixel_integrator #(
    .W (c_v_w)
  ) u_integrator (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .add_en    (w_add_en),
    .increment (c_increment),
    .v         (w_v)
  );

  // Request levels pick the next state: erase > read > expose > convert.
  always_comb begin
    w_next_state = ST_IDLE;
    if (pif.erase_i) begin
      w_next_state = ST_ERASE;
    end else if (pif.read_i) begin
      w_next_state = ST_READ;
    end else if (pif.expose_i) begin
      w_next_state = ST_EXPOSE;
    end else if (pif.convert_i) begin
      w_next_state = ST_CONVERT;
    end
  end

  // Ramp/comparator datapath; ticks only count in CONVERT, entry restarts it.
  always_comb begin
    w_ramp_next    = r_ramp;
    w_data_q_next  = r_data_q;
    w_tripped_next = r_tripped;
    case (r_state)
      ST_ERASE: begin
        w_data_q_next  = '0;
        w_tripped_next = 1'b0;
      end
      ST_CONVERT: begin
        if (pif.ramp_tick_i) begin
          if (!r_tripped && (r_ramp >= w_vi)) begin
            w_data_q_next  = pif.bus_in;
            w_tripped_next = 1'b1;
          end
          if (r_ramp != c_ramp_max) begin
            w_ramp_next = r_ramp + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
    if (w_convert_entry) begin
      w_ramp_next    = '0;
      w_tripped_next = 1'b0;
    end
  end

  // State register and registered outputs; readout drive follows the next
  // state so bus_oe rises together with entry into READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ramp    <= '0;
      r_data_q  <= '0;
      r_tripped <= 1'b0;
      r_bus_out <= '0;
      r_bus_oe  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_ramp    <= w_ramp_next;
      r_data_q  <= w_data_q_next;
      r_tripped <= w_tripped_next;
      r_bus_oe  <= (w_next_state == ST_READ);
      r_bus_out <= (w_next_state == ST_READ) ? w_data_q_next : '0;
    end
  end

  assign pif.bus_out     = r_bus_out;
  assign pif.bus_oe      = r_bus_oe;
  assign pif.conv_done_o = r_tripped;
  assign pif.state_o     = r_state;

endmodule : pixel_adc_responder
`default_nettype wire

// File: tb/tb_pixel_adc_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_adc_responder
// Description : Directed, table-driven bench for pixel_adc_responder. Two
//               instances share the stimulus: A uses PHOTO_RATE=128, B uses
//               PHOTO_RATE=255 for the saturation frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_adc_responder;

  localparam logic [3:0] c_r_none    = 4'b0000;
  localparam logic [3:0] c_r_erase   = 4'b1000;
  localparam logic [3:0] c_r_read    = 4'b0100;
  localparam logic [3:0] c_r_expose  = 4'b0010;
  localparam logic [3:0] c_r_convert = 4'b0001;

  typedef struct {
    logic [3:0]  req;       // {erase, read, expose, convert}
    logic        ticks;     // expose/ramp strobes high every cycle
    logic [7:0]  base;      // bus_in = base + cycle index in this row
    int          n;         // cycles to run
    logic        dut;       // 0 = A, 1 = B
    logic [2:0]  exp_state;
    logic        exp_oe;
    logic [7:0]  exp_out;
    logic        exp_done;
    logic        chk_v;
    logic [15:0] exp_v;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       r_erase = 1'b0, r_read = 1'b0, r_expose = 1'b0, r_convert = 1'b0;
  logic       r_tick = 1'b0;
  logic [7:0] r_bus = 8'd0;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  pixel_adc_responder_if #(.DATA_W(8)) if_a ();
  pixel_adc_responder_if #(.DATA_W(8)) if_b ();

  assign if_a.erase_i = r_erase;   assign if_b.erase_i = r_erase;
  assign if_a.read_i = r_read;     assign if_b.read_i = r_read;
  assign if_a.expose_i = r_expose; assign if_b.expose_i = r_expose;
  assign if_a.convert_i = r_convert; assign if_b.convert_i = r_convert;
  assign if_a.expose_tick_i = r_tick; assign if_b.expose_tick_i = r_tick;
  assign if_a.ramp_tick_i = r_tick;   assign if_b.ramp_tick_i = r_tick;
  assign if_a.bus_in = r_bus;         assign if_b.bus_in = r_bus;

  pixel_adc_responder #(.DATA_W(8), .FRAC_W(8), .PHOTO_RATE(128)) dut_a (
    .clk   (clk),
    .reset (reset),
    .pif   (if_a.slave)
  );

  pixel_adc_responder #(.DATA_W(8), .FRAC_W(8), .PHOTO_RATE(255)) dut_b (
    .clk   (clk),
    .reset (reset),
    .pif   (if_b.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hold the given request levels for n cycles; returns at posedge+1.
  task automatic run(input logic [3:0] req, input logic ticks, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      {r_erase, r_read, r_expose, r_convert} = req;
      r_tick = ticks;
      r_bus  = base + 8'(i);
      @(posedge clk);
      #1;
    end
    r_tick = 1'b0;
  endtask

  function automatic void add(input logic [3:0] req, input logic ticks, input logic [7:0] base,
                              input int n, input logic dut, input logic [2:0] st,
                              input logic oe, input logic [7:0] out, input logic done,
                              input logic chk_v, input logic [15:0] v);
    vecs.push_back('{req, ticks, base, n, dut, st, oe, out, done, chk_v, v});
  endfunction

  initial begin
    // Nominal frame on A: vi = 0x7F80 >> 8 = 127, trip when ramp = 127.
    add(c_r_erase,   0, 0,   5,   0, 1, 0, 0,   0, 1, 16'h0000);
    add(c_r_expose,  0, 0,   1,   0, 2, 0, 0,   0, 0, 0);
    add(c_r_expose,  1, 0,   255, 0, 2, 0, 0,   0, 1, 16'h7F80);
    add(c_r_convert, 0, 0,   1,   0, 3, 0, 0,   0, 1, 16'h7F80);
    add(c_r_convert, 1, 0,   127, 0, 3, 0, 0,   0, 0, 0);
    add(c_r_convert, 1, 127, 1,   0, 3, 0, 0,   1, 0, 0);
    add(c_r_convert, 1, 128, 128, 0, 3, 0, 0,   1, 0, 0);
    add(c_r_read,    0, 0,   1,   0, 4, 1, 127, 1, 0, 0);
    add(c_r_read,    0, 0,   4,   0, 4, 1, 127, 1, 0, 0);
    add(c_r_none,    0, 0,   1,   0, 0, 0, 0,   1, 1, 16'h7F80);
    // Aborted conversion at ramp 50, then a full re-conversion from 0.
    add(c_r_convert, 0, 0,   1,   0, 3, 0, 0,   0, 0, 0);
    add(c_r_convert, 1, 200, 51,  0, 3, 0, 0,   0, 0, 0);
    add(c_r_none,    0, 0,   1,   0, 0, 0, 0,   0, 0, 0);
    add(c_r_read,    0, 0,   1,   0, 4, 1, 127, 0, 0, 0);
    add(c_r_convert, 0, 0,   1,   0, 3, 0, 0,   0, 0, 0);
    add(c_r_convert, 1, 0,   127, 0, 3, 0, 0,   0, 0, 0);
    add(c_r_convert, 1, 8'h55, 1, 0, 3, 0, 0,   1, 0, 0);
    add(c_r_read,    0, 0,   1,   0, 4, 1, 8'h55, 1, 0, 0);
    // Priority: read beats convert (no entry, ramp idle); erase beats read.
    add(c_r_read | c_r_convert, 1, 0, 3, 0, 4, 1, 8'h55, 1, 0, 0);
    add(c_r_erase | c_r_read,   0, 0, 2, 0, 1, 0, 0,     0, 1, 16'h0000);
    // Dark pixel: vi = 0 trips on the first ramp tick.
    add(c_r_expose,  0, 0,   1,   0, 2, 0, 0,   0, 0, 0);
    add(c_r_convert, 0, 0,   1,   0, 3, 0, 0,   0, 1, 16'h0000);
    add(c_r_convert, 1, 9,   1,   0, 3, 0, 0,   1, 0, 0);
    add(c_r_convert, 1, 20,  3,   0, 3, 0, 0,   1, 0, 0);
    add(c_r_read,    0, 0,   1,   0, 4, 1, 9,   1, 0, 0);
    // Saturation on B: 255*256 = 0xFF00, one more tick lands on 0xFFFF exactly.
    add(c_r_erase,   0, 0,   2,   1, 1, 0, 0,   0, 1, 16'h0000);
    add(c_r_expose,  0, 0,   1,   1, 2, 0, 0,   0, 0, 0);
    add(c_r_expose,  1, 0,   256, 1, 2, 0, 0,   0, 1, 16'hFF00);
    add(c_r_expose,  1, 0,   1,   1, 2, 0, 0,   0, 1, 16'hFFFF);
    add(c_r_expose,  1, 0,   43,  1, 2, 0, 0,   0, 1, 16'hFFFF);
    add(c_r_convert, 0, 0,   1,   1, 3, 0, 0,   0, 0, 0);
    add(c_r_convert, 1, 0,   255, 1, 3, 0, 0,   0, 0, 0);
    add(c_r_convert, 1, 255, 1,   1, 3, 0, 0,   1, 0, 0);
    add(c_r_read,    0, 0,   1,   1, 4, 1, 255, 1, 1, 16'hFFFF);
    add(c_r_none,    0, 0,   1,   1, 0, 0, 0,   1, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {29'd0, if_a.state_o}, 32'd0);
    check("reset_oe",    {31'd0, if_a.bus_oe}, 32'd0);
    check("reset_out",   {24'd0, if_a.bus_out}, 32'd0);
    check("reset_done",  {31'd0, if_a.conv_done_o}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      logic [2:0]  a_st;
      logic        a_oe, a_done;
      logic [7:0]  a_out;
      logic [15:0] a_v;
      run(vecs[k].req, vecs[k].ticks, vecs[k].base, vecs[k].n);
      a_st   = vecs[k].dut ? if_b.state_o     : if_a.state_o;
      a_oe   = vecs[k].dut ? if_b.bus_oe      : if_a.bus_oe;
      a_out  = vecs[k].dut ? if_b.bus_out     : if_a.bus_out;
      a_done = vecs[k].dut ? if_b.conv_done_o : if_a.conv_done_o;
      a_v    = vecs[k].dut ? dut_b.w_v        : dut_a.w_v;
      check($sformatf("vec%0d_state", k), {29'd0, a_st},   {29'd0, vecs[k].exp_state});
      check($sformatf("vec%0d_oe", k),    {31'd0, a_oe},   {31'd0, vecs[k].exp_oe});
      check($sformatf("vec%0d_out", k),   {24'd0, a_out},  {24'd0, vecs[k].exp_out});
      check($sformatf("vec%0d_done", k),  {31'd0, a_done}, {31'd0, vecs[k].exp_done});
      if (vecs[k].chk_v) begin
        check($sformatf("vec%0d_v", k), {16'd0, a_v}, {16'd0, vecs[k].exp_v});
      end
    end

    // Asynchronous reset in the middle of a conversion (A: vi = 2, ramp at 2).
    run(c_r_erase, 0, 0, 1);
    run(c_r_expose, 0, 0, 1);
    run(c_r_expose, 1, 0, 4);
    run(c_r_convert, 0, 0, 1);
    run(c_r_convert, 1, 8'h30, 2);
    check("conv_pre_state", {29'd0, if_a.state_o}, 32'd3);
    check("conv_pre_v", {16'd0, dut_a.w_v}, 32'h0200);
    #2;
    reset = 1'b1;
    #1;
    check("conv_rst_state", {29'd0, if_a.state_o}, 32'd0);
    check("conv_rst_v",     {16'd0, dut_a.w_v}, 32'd0);
    check("conv_rst_oe",    {31'd0, if_a.bus_oe}, 32'd0);
    {r_erase, r_read, r_expose, r_convert} = c_r_none;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset while reading: trip at tick 2 latches 0x32.
    run(c_r_erase, 0, 0, 1);
    run(c_r_expose, 0, 0, 1);
    run(c_r_expose, 1, 0, 4);
    run(c_r_convert, 0, 0, 1);
    run(c_r_convert, 1, 8'h30, 3);
    run(c_r_read, 0, 0, 2);
    check("read_pre_oe",  {31'd0, if_a.bus_oe}, 32'd1);
    check("read_pre_out", {24'd0, if_a.bus_out}, 32'h32);
    #2;
    reset = 1'b1;
    #1;
    check("read_rst_state", {29'd0, if_a.state_o}, 32'd0);
    check("read_rst_oe",    {31'd0, if_a.bus_oe}, 32'd0);
    check("read_rst_out",   {24'd0, if_a.bus_out}, 32'd0);
    check("read_rst_done",  {31'd0, if_a.conv_done_o}, 32'd0);
    check("read_rst_v",     {16'd0, dut_a.w_v}, 32'd0);
    {r_erase, r_read, r_expose, r_convert} = c_r_none;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pixel_adc_responder
`default_nettype wire
